m68k_bus_master: RTL and testbench

M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

---
 rtl/m68k_bus_master.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_m68k_bus_master.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: turns a local word request into one MC68000-style
// asynchronous bus cycle: address, AS/DS strobes, wait for DTACK/BERR or
// timeout, then recovery.
// Optional feature: define M68K_BUS_ARB_EN to add BR/BG/BGACK bus arbitration
// before each cycle. The default build has no arbitration: BRn and BGACKn are
// tied high and BGn is ignored.
module m68k_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk12,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  be,
    input  logic [23:1] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [23:1] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    output logic        ASn,
    output logic        R_Wn,
    output logic        UDSn,
    output logic        LDSn,
    output logic        addr_oe,
    output logic        data_oe,
    input  logic        DTACKn,
    input  logic        BERRn,
    output logic        BRn,
    output logic        BGACKn,
    input  logic        BGn
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ADDR,
        S_STROBE,
        S_DS,
        S_WAIT,
        S_END,
        S_RECOVER
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [1:0]         dtack_sync_q;
    logic [1:0]         berr_sync_q;
    logic               dtack_n_s;
    logic               berr_n_s;

    logic               we_q;
    logic [1:0]         be_q;
    logic               err_flag_q;
    logic               err_flag_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               timeout_hit;

    logic               load_req;
    logic               load_rdata;
    logic               ack_d;
    logic               err_d;
    logic               busy_d;
    logic               as_n_d;
    logic               uds_n_d;
    logic               lds_n_d;
    logic               r_wn_d;
    logic               addr_oe_d;
    logic               data_oe_d;

`ifdef M68K_BUS_ARB_EN
    logic [1:0]         bg_sync_q;
    logic               bg_n_s;
    logic               br_n_d;
    logic               bgack_n_d;
`endif

    // Two-flop synchronizers for the asynchronous responder inputs (idle high)
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            dtack_sync_q <= 2'b11;
            berr_sync_q  <= 2'b11;
        end else begin
            dtack_sync_q <= {dtack_sync_q[0], DTACKn};
            berr_sync_q  <= {berr_sync_q[0], BERRn};
        end
    end

    assign dtack_n_s = dtack_sync_q[1];
    assign berr_n_s  = berr_sync_q[1];

`ifdef M68K_BUS_ARB_EN
    // Bus-grant synchronizer
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            bg_sync_q <= 2'b11;
        end else begin
            bg_sync_q <= {bg_sync_q[0], BGn};
        end
    end

    assign bg_n_s = bg_sync_q[1];
`else
    logic unused_bgn;
    assign unused_bgn = BGn;
    assign BRn        = 1'b1;
    assign BGACKn     = 1'b1;
`endif

    // WAIT has run TIMEOUT_CYCLES cycles once this cycle completes
    assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES;

    // State register
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of the registered bus/handshake outputs
    always_comb begin
        state_d    = state_q;
        load_req   = 1'b0;
        load_rdata = 1'b0;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy;
        as_n_d     = 1'b1;
        uds_n_d    = 1'b1;
        lds_n_d    = 1'b1;
        r_wn_d     = R_Wn;
        addr_oe_d  = addr_oe;
        data_oe_d  = 1'b0;
`ifdef M68K_BUS_ARB_EN
        br_n_d     = 1'b1;
        bgack_n_d  = BGACKn;
`endif

        case (state_q)
            S_IDLE: begin
                r_wn_d    = 1'b1;
                addr_oe_d = 1'b0;
                if (req) begin
                    if (be == 2'b00) begin
                        // Nothing to transfer: fail at once without touching the bus
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        load_req   = 1'b1;
                        busy_d     = 1'b1;
                        err_flag_d = 1'b0;
`ifdef M68K_BUS_ARB_EN
                        state_d    = S_ARB;
                        br_n_d     = 1'b0;
`else
                        state_d    = S_ADDR;
                        addr_oe_d  = 1'b1;
                        r_wn_d     = ~we;
`endif
                    end
                end
            end

            S_ARB: begin
`ifdef M68K_BUS_ARB_EN
                // Take the bus only once granted and the previous owner's DTACK is gone
                if (!bg_n_s && dtack_n_s) begin
                    state_d   = S_ADDR;
                    bgack_n_d = 1'b0;
                    addr_oe_d = 1'b1;
                    r_wn_d    = ~we_q;
                end else begin
                    br_n_d    = 1'b0;
                end
`else
                state_d   = S_ADDR;
                addr_oe_d = 1'b1;
                r_wn_d    = ~we_q;
`endif
            end

            S_ADDR: begin
                state_d = S_STROBE;
                as_n_d  = 1'b0;
                if (we_q) begin
                    data_oe_d = 1'b1;
                end else begin
                    uds_n_d = ~be_q[1];
                    lds_n_d = ~be_q[0];
                end
            end

            S_STROBE: begin
                as_n_d  = 1'b0;
                uds_n_d = ~be_q[1];
                lds_n_d = ~be_q[0];
                if (we_q) begin
                    state_d   = S_DS;
                    data_oe_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end

            S_DS: begin
                state_d   = S_WAIT;
                cnt_d     = '0;
                as_n_d    = 1'b0;
                uds_n_d   = ~be_q[1];
                lds_n_d   = ~be_q[0];
                data_oe_d = 1'b1;
            end

            S_WAIT: begin
                data_oe_d = we_q;
                if (!berr_n_s) begin
                    state_d    = S_END;
                    err_flag_d = 1'b1;
                end else if (!dtack_n_s) begin
                    state_d    = S_END;
                    load_rdata = ~we_q;
                end else if (timeout_hit) begin
                    state_d    = S_END;
                    err_flag_d = 1'b1;
                end else begin
                    as_n_d  = 1'b0;
                    uds_n_d = ~be_q[1];
                    lds_n_d = ~be_q[0];
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_END: begin
                state_d = S_RECOVER;
            end

            S_RECOVER: begin
                // Hand the bus back only after the responder has released both lines
                if (dtack_n_s && berr_n_s) begin
                    state_d   = S_IDLE;
                    ack_d     = 1'b1;
                    err_d     = err_flag_q;
                    busy_d    = 1'b0;
                    addr_oe_d = 1'b0;
                    r_wn_d    = 1'b1;
`ifdef M68K_BUS_ARB_EN
                    bgack_n_d = 1'b1;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latches, timeout counter and error flag
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
        end else begin
            if (load_req) begin
                we_q      <= we;
                be_q      <= be;
                bus_addr  <= addr;
                bus_wdata <= wdata;
            end
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    // Registered bus strobes, enables and local handshake
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            ASn     <= 1'b1;
            UDSn    <= 1'b1;
            LDSn    <= 1'b1;
            R_Wn    <= 1'b1;
            addr_oe <= 1'b0;
            data_oe <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ASn     <= as_n_d;
            UDSn    <= uds_n_d;
            LDSn    <= lds_n_d;
            R_Wn    <= r_wn_d;
            addr_oe <= addr_oe_d;
            data_oe <= data_oe_d;
            ack     <= ack_d;
            err     <= err_d;
            busy    <= busy_d;
        end
    end

    // Read data capture on a clean read completion
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (load_rdata) begin
            rdata <= bus_rdata;
        end
    end

`ifdef M68K_BUS_ARB_EN
    // Arbitration outputs
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            BRn    <= 1'b1;
            BGACKn <= 1'b1;
        end else begin
            BRn    <= br_n_d;
            BGACKn <= bgack_n_d;
        end
    end
`endif

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed self-checking bench for m68k_bus_master (TIMEOUT_CYCLES = 16).
module tb_m68k_bus_master;

    logic        clk12 = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [23:1] addr = '0;
    logic [15:0] wdata = '0;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic        busy;
    logic [23:1] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        ASn;
    logic        R_Wn;
    logic        UDSn;
    logic        LDSn;
    logic        addr_oe;
    logic        data_oe;
    logic        DTACKn = 1'b1;
    logic        BERRn = 1'b1;
    logic        BRn;
    logic        BGACKn;
    logic        bg_n = 1'b1;
    logic        arb_hold = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_rdata = 16'h0000;

    m68k_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk12     (clk12),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .ASn       (ASn),
        .R_Wn      (R_Wn),
        .UDSn      (UDSn),
        .LDSn      (LDSn),
        .addr_oe   (addr_oe),
        .data_oe   (data_oe),
        .DTACKn    (DTACKn),
        .BERRn     (BERRn),
        .BRn       (BRn),
        .BGACKn    (BGACKn),
        .BGn       (bg_n)
    );

    always #5 clk12 = ~clk12;

    // Simple arbiter: grants one cycle after a bus request unless held off
    always @(posedge clk12) bg_n <= arb_hold ? 1'b1 : BRn;

    task automatic issue(input logic w, input logic [1:0] b, input logic [23:1] a, input logic [15:0] d);
        @(negedge clk12);
        we = w; be = b; addr = a; wdata = d; req = 1'b1;
        @(posedge clk12); #1;
        req = 1'b0;
    endtask

    task automatic wait_ack(input int max_cyc, output logic seen, output logic e, output int cyc);
        seen = 1'b0; e = 1'b0; cyc = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk12);
            if (ack === 1'b1) begin
                seen = 1'b1; e = err; cyc = i;
                break;
            end
        end
    endtask

    // Responder: assert DTACK/BERR 'delay' cycles after AS, release when AS negates
    task automatic respond(input int delay, input logic [15:0] data, input logic dt, input logic be_rr);
        int n;
        n = 0;
        while (ASn !== 1'b0 && n < 200) begin @(posedge clk12); #1; n++; end
        repeat (delay) begin @(posedge clk12); #1; end
        if (dt) DTACKn = 1'b0;
        if (be_rr) BERRn = 1'b0;
        bus_rdata = data;
        n = 0;
        while (ASn !== 1'b1 && n < 200) begin @(posedge clk12); #1; n++; end
        DTACKn = 1'b1; BERRn = 1'b1; bus_rdata = 16'h0000;
    endtask

    task automatic release_on_as_high();
        int n;
        n = 0;
        while (ASn !== 1'b0 && n < 50) begin @(posedge clk12); #1; n++; end
        n = 0;
        while (ASn !== 1'b1 && n < 50) begin @(posedge clk12); #1; n++; end
        DTACKn = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk12);
        checks++;
        if ({ASn, UDSn, LDSn, R_Wn, BRn, BGACKn, addr_oe, data_oe, ack, err, busy} !== 11'b111111_00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b",
                     {ASn, UDSn, LDSn, R_Wn, BRn, BGACKn, addr_oe, data_oe, ack, err, busy}, 11'b111111_00000);
        end
        checks++;
        if (rdata !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h want 0000", rdata);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk12);
        checks++;
        if ({ASn, UDSn, LDSn, addr_oe, ack, busy} !== 6'b111_000) begin
            errors++; $display("FAIL reset_release_idle: got %b want 111000", {ASn, UDSn, LDSn, addr_oe, ack, busy});
        end
    endtask

    task automatic test_read();
        logic seen, e, saw_ds, rw_bad, addr_seen;
        logic [23:1] addr_obs;
        seen = 0; e = 0; saw_ds = 0; rw_bad = 0; addr_seen = 0; addr_obs = '0;
        issue(1'b0, 2'b11, 23'h03c000, 16'h0000);
        fork
            respond(3, 16'hA55A, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk12);
                    if (addr_oe === 1'b1 && !addr_seen) begin addr_seen = 1; addr_obs = bus_addr; end
                    if (addr_oe === 1'b1 && R_Wn !== 1'b1) rw_bad = 1;
                    if (ASn === 1'b0 && UDSn === 1'b0 && LDSn === 1'b0) saw_ds = 1;
                    if (ack === 1'b1) begin seen = 1; e = err; break; end
                end
            end
        join
        exp_rdata = 16'hA55A;
        checks++;
        if (addr_obs !== 23'h03c000) begin errors++; $display("FAIL read_bus_addr: got %h want 03c000", addr_obs); end
        checks++;
        if (rw_bad !== 1'b0) begin errors++; $display("FAIL read_R_Wn: R_Wn low during read, got %b want 0", rw_bad); end
        checks++;
        if (saw_ds !== 1'b1) begin errors++; $display("FAIL read_strobes: AS+UDS+LDS low seen=%b want 1", saw_ds); end
        checks++;
        if ({seen, e} !== 2'b10) begin errors++; $display("FAIL read_ack: ack/err got %b want 10", {seen, e}); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL read_rdata: got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_write();
        logic seen, e, lds_low, rw_bad;
        int first_doe, first_uds;
        logic [15:0] wd_obs;
        seen = 0; e = 0; lds_low = 0; rw_bad = 0; first_doe = -1; first_uds = -1; wd_obs = '0;
        issue(1'b1, 2'b10, 23'h03d000, 16'h4100);
        fork
            respond(2, 16'h0000, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk12);
                    if (data_oe === 1'b1 && first_doe < 0) begin first_doe = i; wd_obs = bus_wdata; end
                    if (UDSn === 1'b0 && first_uds < 0) first_uds = i;
                    if (LDSn === 1'b0) lds_low = 1;
                    if (addr_oe === 1'b1 && R_Wn !== 1'b0) rw_bad = 1;
                    if (ack === 1'b1) begin seen = 1; e = err; break; end
                end
            end
        join
        checks++;
        if (first_doe < 0 || first_uds - first_doe != 1) begin
            errors++; $display("FAIL write_doe_before_uds: data_oe at %0d UDSn at %0d, want UDSn one cycle later", first_doe, first_uds);
        end
        checks++;
        if (wd_obs !== 16'h4100) begin errors++; $display("FAIL write_bus_wdata: got %h want 4100", wd_obs); end
        checks++;
        if ({lds_low, rw_bad} !== 2'b00) begin errors++; $display("FAIL write_lds_rw: lds_low/rw_bad got %b want 00", {lds_low, rw_bad}); end
        checks++;
        if ({seen, e} !== 2'b10) begin errors++; $display("FAIL write_ack: ack/err got %b want 10", {seen, e}); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL write_rdata_kept: got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_latency();
        logic seen, e;
        int cyc;
        DTACKn = 1'b0; bus_rdata = 16'h1234;
        repeat (3) @(negedge clk12);
        issue(1'b0, 2'b01, 23'h000100, 16'h0000);
        fork
            wait_ack(30, seen, e, cyc);
            release_on_as_high();
        join
        exp_rdata = 16'h1234;
        bus_rdata = 16'h0000;
        checks++;
        if (!seen || e !== 1'b0 || cyc != 7) begin
            errors++; $display("FAIL read_latency: ack=%b err=%b cycles=%0d want ack=1 err=0 cycles=7", seen, e, cyc);
        end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL latency_rdata: got %h want %h", rdata, exp_rdata); end
        DTACKn = 1'b0;
        repeat (3) @(negedge clk12);
        issue(1'b1, 2'b11, 23'h000200, 16'hBEEF);
        fork
            wait_ack(30, seen, e, cyc);
            release_on_as_high();
        join
        checks++;
        if (!seen || e !== 1'b0 || cyc != 8) begin
            errors++; $display("FAIL write_latency: ack=%b err=%b cycles=%0d want ack=1 err=0 cycles=8", seen, e, cyc);
        end
    endtask

    task automatic test_timeout();
        logic seen, e;
        logic [2:0] strobes;
        int as_low;
        seen = 0; e = 0; as_low = 0; strobes = 3'b000;
        bus_rdata = 16'hDEAD;
        issue(1'b0, 2'b11, 23'h010000, 16'h0000);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk12);
            if (ASn === 1'b0) as_low++;
            if (ack === 1'b1) begin seen = 1; e = err; strobes = {ASn, UDSn, LDSn}; break; end
        end
        bus_rdata = 16'h0000;
        checks++;
        if ({seen, e} !== 2'b11) begin errors++; $display("FAIL timeout_ack: ack/err got %b want 11", {seen, e}); end
        checks++;
        if (as_low != 17) begin errors++; $display("FAIL timeout_wait_len: AS low %0d cycles want 17", as_low); end
        checks++;
        if (strobes !== 3'b111) begin errors++; $display("FAIL timeout_strobes: got %b want 111", strobes); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL timeout_rdata: got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_berr_dtack();
        logic seen, e, released, rel_at_ack;
        seen = 0; e = 0; released = 0; rel_at_ack = 0;
        issue(1'b0, 2'b11, 23'h020000, 16'h0000);
        fork
            begin
                int n;
                n = 0;
                while (ASn !== 1'b0 && n < 50) begin @(posedge clk12); #1; n++; end
                repeat (2) begin @(posedge clk12); #1; end
                DTACKn = 1'b0; BERRn = 1'b0; bus_rdata = 16'hBEEF;
                n = 0;
                while (ASn !== 1'b1 && n < 50) begin @(posedge clk12); #1; n++; end
                repeat (4) begin @(posedge clk12); #1; end
                DTACKn = 1'b1;
                repeat (4) begin @(posedge clk12); #1; end
                BERRn = 1'b1; bus_rdata = 16'h0000; released = 1;
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    @(negedge clk12);
                    if (ack === 1'b1) begin seen = 1; e = err; rel_at_ack = released; break; end
                end
            end
        join
        checks++;
        if ({seen, e} !== 2'b11) begin errors++; $display("FAIL berr_ack: ack/err got %b want 11", {seen, e}); end
        checks++;
        if (rel_at_ack !== 1'b1) begin errors++; $display("FAIL berr_wait_release: released at ack %b want 1", rel_at_ack); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL berr_rdata: got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_be_zero();
        logic seen, e;
        int cyc;
        issue(1'b0, 2'b00, 23'h030000, 16'h0000);
        wait_ack(3, seen, e, cyc);
        checks++;
        if (!seen || e !== 1'b1 || cyc != 1) begin
            errors++; $display("FAIL be_zero_ack: ack=%b err=%b cycle=%0d want 1 1 1", seen, e, cyc);
        end
        checks++;
        if ({busy, ASn, addr_oe} !== 3'b010) begin
            errors++; $display("FAIL be_zero_no_cycle: busy/ASn/addr_oe got %b want 010", {busy, ASn, addr_oe});
        end
    endtask

    task automatic test_reset_mid();
        int acks, as_low;
        acks = 0; as_low = 0;
        issue(1'b0, 2'b11, 23'h040000, 16'h0000);
        repeat (5) @(negedge clk12);
        checks++;
        if ({ASn, UDSn, LDSn} !== 3'b000) begin errors++; $display("FAIL midreset_in_wait: strobes %b want 000", {ASn, UDSn, LDSn}); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ASn, UDSn, LDSn, busy} !== 4'b1110) begin
            errors++; $display("FAIL midreset_async: strobes/busy got %b want 1110", {ASn, UDSn, LDSn, busy});
        end
        @(negedge clk12);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk12);
            if (ack === 1'b1) acks++;
            if (ASn !== 1'b1) as_low++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL midreset_no_ack: acks %0d want 0", acks); end
        checks++;
        if (as_low != 0) begin errors++; $display("FAIL midreset_as_idle: AS low %0d cycles want 0", as_low); end
    endtask

`ifdef M68K_BUS_ARB_EN
    task automatic test_arb();
        logic seen, e;
        int viol, first_bgack, first_as;
        seen = 0; e = 0; viol = 0; first_bgack = -1; first_as = -1;
        arb_hold = 1'b1;
        issue(1'b0, 2'b11, 23'h050000, 16'h0000);
        fork
            respond(2, 16'h5A5A, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk12);
                    if (BRn !== 1'b0 || ASn !== 1'b1) viol++;
                end
                arb_hold = 1'b0;
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk12);
                    if (BGACKn === 1'b0 && first_bgack < 0) first_bgack = i;
                    if (ASn === 1'b0 && first_as < 0) first_as = i;
                    if (ack === 1'b1) begin seen = 1; e = err; break; end
                end
            end
        join
        exp_rdata = 16'h5A5A;
        checks++;
        if (viol != 0) begin errors++; $display("FAIL arb_hold: %0d cycles without BRn=0/ASn=1, want 0", viol); end
        checks++;
        if (first_bgack < 0 || first_as <= first_bgack) begin
            errors++; $display("FAIL arb_order: BGACKn low at %0d ASn low at %0d, want BGACKn first", first_bgack, first_as);
        end
        checks++;
        if ({seen, e, BGACKn} !== 3'b101) begin errors++; $display("FAIL arb_ack: ack/err/BGACKn got %b want 101", {seen, e, BGACKn}); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL arb_rdata: got %h want %h", rdata, exp_rdata); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        repeat (3) @(negedge clk12);
        test_write();
        repeat (3) @(negedge clk12);
`ifndef M68K_BUS_ARB_EN
        test_latency();
        repeat (3) @(negedge clk12);
`endif
        test_timeout();
        repeat (3) @(negedge clk12);
        test_berr_dtack();
        repeat (3) @(negedge clk12);
        test_be_zero();
        repeat (3) @(negedge clk12);
        test_reset_mid();
`ifdef M68K_BUS_ARB_EN
        repeat (3) @(negedge clk12);
        test_arb();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
